// File: rtl/fpu_pipe_top.sv
// Pipelined FPU wrapper: issue handshake, operand stage driving the external
// combinational datapath, LAT-1 result stages with global stall, result
// masking by destination class and an accrued fflags image.
module fpu_pipe_top #(
  parameter int          EXP          = 8,
  parameter int          MAN          = 23,
  parameter int          FLEN         = 1 + EXP + MAN,
  parameter int          LAT          = 2,
  parameter int          TAGW         = 4,
  parameter logic [23:0] INT_DST_MASK = 24'h204E80
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [23:0]     in_op,
  input  logic [2:0]      in_frm,
  input  logic [TAGW-1:0] in_tag,
  input  logic [FLEN-1:0] in_a,
  input  logic [FLEN-1:0] in_b,
  input  logic [FLEN-1:0] in_c,
  input  logic [31:0]     in_int,
  output logic [23:0]     dp_op,
  output logic [2:0]      dp_frm,
  output logic [FLEN-1:0] dp_a,
  output logic [FLEN-1:0] dp_b,
  output logic [FLEN-1:0] dp_c,
  output logic [31:0]     dp_int,
  input  logic [FLEN-1:0] dp_fp_res,
  input  logic [31:0]     dp_int_res,
  input  logic [4:0]      dp_flags,
  input  logic            dp_exc,
  input  logic [FLEN-1:0] dp_exc_res,
  input  logic            dp_exc_nv,
  input  logic            dp_exc_dz,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FLEN-1:0] out_fp,
  output logic [31:0]     out_int,
  output logic [4:0]      out_flags,
  output logic [TAGW-1:0] out_tag,
  output logic            out_op_err,
  output logic [4:0]      fflags,
  input  logic            fflags_clr,
  output logic            busy
);

  localparam int NR = LAT - 1;  // number of result stages

  typedef struct packed {
    logic [23:0]     op;
    logic [2:0]      frm;
    logic [TAGW-1:0] tag;
    logic [FLEN-1:0] a;
    logic [FLEN-1:0] b;
    logic [FLEN-1:0] c;
    logic [31:0]     ival;
  } req_t;

  typedef struct packed {
    logic [FLEN-1:0] fp;
    logic [31:0]     ival;
    logic [4:0]      flags;
    logic [TAGW-1:0] tag;
    logic            err;
  } res_t;

  // vld_q[0] is the operand stage, vld_q[1..LAT-1] the result stages
  logic [LAT-1:0]   vld_q;
  req_t             s1_q;
  res_t [NR:1]      res_q;
  res_t             res_d;
  logic [4:0]       fflags_q, fflags_d;
  logic             stall, accept, hs, illegal;
  logic [21:0]      oh;
  logic [31:0]      exc_int;

  assign stall    = vld_q[LAT-1] & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;
  assign hs       = out_valid & out_ready;

  // exception result routed to the integer file is the low 32 bits, zero-extended
  if (FLEN >= 32) begin : g_exc_trunc
    assign exc_int = dp_exc_res[31:0];
  end else begin : g_exc_ext
    assign exc_int = {{(32-FLEN){1'b0}}, dp_exc_res};
  end

  assign oh      = s1_q.op[21:0];
  assign illegal = (oh == '0) || ((oh & (oh - 22'd1)) != '0);

  // form the masked result of the op in the operand stage; bubbles give all-zero
  always_comb begin
    res_d     = '0;
    res_d.tag = s1_q.tag;
    if (vld_q[0]) begin
      if (illegal) begin
        res_d.flags = 5'b10000;
        res_d.err   = 1'b1;
      end else if (dp_exc) begin
        res_d.fp    = dp_exc_res;
        res_d.ival  = s1_q.op[7] ? exc_int : 32'h0;
        res_d.flags = {dp_exc_nv, dp_exc_dz, 3'b000};
      end else if ((s1_q.op & INT_DST_MASK) != '0) begin
        res_d.ival  = dp_int_res;
        res_d.flags = dp_flags;
      end else begin
        res_d.fp    = dp_fp_res;
        res_d.flags = dp_flags;
      end
    end
  end

  // whole pipe advances together unless the output is stalled
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      vld_q <= '0;
      s1_q  <= '0;
      res_q <= '0;
    end else if (!stall) begin
      vld_q    <= {vld_q[LAT-2:0], accept};
      s1_q     <= accept ? '{op: in_op, frm: in_frm, tag: in_tag, a: in_a,
                             b: in_b, c: in_c, ival: in_int} : '0;
      res_q[1] <= res_d;
      for (int i = 2; i <= NR; i++) res_q[i] <= res_q[i-1];
    end
  end

  // accrued flags: clear applies before the retiring op's flags are OR-ed in
  always_comb begin
    fflags_d = fflags_q;
    if (hs)              fflags_d = (fflags_clr ? 5'b0 : fflags_q) | out_flags;
    else if (fflags_clr) fflags_d = 5'b0;
  end

  // fflags CSR image
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) fflags_q <= '0;
    else        fflags_q <= fflags_d;
  end

  assign dp_op      = s1_q.op;
  assign dp_frm     = s1_q.frm;
  assign dp_a       = s1_q.a;
  assign dp_b       = s1_q.b;
  assign dp_c       = s1_q.c;
  assign dp_int     = s1_q.ival;
  assign out_valid  = vld_q[LAT-1];
  assign out_fp     = res_q[NR].fp;
  assign out_int    = res_q[NR].ival;
  assign out_flags  = res_q[NR].flags;
  assign out_tag    = res_q[NR].tag;
  assign out_op_err = res_q[NR].err;
  assign fflags     = fflags_q;
  assign busy       = |vld_q;

endmodule

// File: tb/tb_fpu_pipe_top.sv
// Directed bench for fpu_pipe_top: LAT=2 instance for function/latency/fflags/
// reset, LAT=3 instance for backpressure ordering.
module tb_fpu_pipe_top;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  logic fflags_clr = 1'b0;
  always #5 clk = ~clk;

  // LAT=2 instance
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_op_err, busy;
  logic [23:0] in_op = '0, dp_op;
  logic [2:0]  in_frm = '0, dp_frm;
  logic [3:0]  in_tag = '0, out_tag;
  logic [31:0] in_a = '0, in_b = '0, in_c = '0, in_int = '0;
  logic [31:0] dp_a, dp_b, dp_c, dp_int, dp_fp_res, dp_int_res, dp_exc_res, out_fp, out_int;
  logic [4:0]  dp_flags, out_flags, fflags;
  logic        dp_exc, dp_exc_nv, dp_exc_dz;

  // stand-in datapath: result = c, int result = int operand, flags = b[4:0],
  // frm=7 raises an input exception with dz taken from b[0]
  assign dp_fp_res  = dp_c;
  assign dp_int_res = dp_int;
  assign dp_flags   = dp_b[4:0];
  assign dp_exc     = (dp_frm == 3'b111);
  assign dp_exc_res = 32'h7FC00000;
  assign dp_exc_nv  = 1'b1;
  assign dp_exc_dz  = dp_b[0];

  fpu_pipe_top #(.LAT(2)) u_dut (
    .clk(clk), .rst_l(rst_l), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_frm(in_frm), .in_tag(in_tag), .in_a(in_a), .in_b(in_b),
    .in_c(in_c), .in_int(in_int), .dp_op(dp_op), .dp_frm(dp_frm), .dp_a(dp_a),
    .dp_b(dp_b), .dp_c(dp_c), .dp_int(dp_int), .dp_fp_res(dp_fp_res),
    .dp_int_res(dp_int_res), .dp_flags(dp_flags), .dp_exc(dp_exc),
    .dp_exc_res(dp_exc_res), .dp_exc_nv(dp_exc_nv), .dp_exc_dz(dp_exc_dz),
    .out_valid(out_valid), .out_ready(out_ready), .out_fp(out_fp), .out_int(out_int),
    .out_flags(out_flags), .out_tag(out_tag), .out_op_err(out_op_err),
    .fflags(fflags), .fflags_clr(fflags_clr), .busy(busy));

  // LAT=3 instance, datapath tied off; only ordering/handshake matter here
  logic        in_valid3 = 1'b0, in_ready3, out_valid3, out_ready3 = 1'b1, out_op_err3, busy3;
  logic [23:0] in_op3 = 24'h1, dp_op3;
  logic [2:0]  dp_frm3;
  logic [3:0]  in_tag3 = '0, out_tag3;
  logic [31:0] dp_a3, dp_b3, dp_c3, dp_int3, out_fp3, out_int3;
  logic [4:0]  out_flags3, fflags3;

  fpu_pipe_top #(.LAT(3)) u_dut3 (
    .clk(clk), .rst_l(rst_l), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_op(in_op3), .in_frm(3'b000), .in_tag(in_tag3), .in_a(32'h0), .in_b(32'h0),
    .in_c(32'h0), .in_int(32'h0), .dp_op(dp_op3), .dp_frm(dp_frm3), .dp_a(dp_a3),
    .dp_b(dp_b3), .dp_c(dp_c3), .dp_int(dp_int3), .dp_fp_res(32'h0),
    .dp_int_res(32'h0), .dp_flags(5'b0), .dp_exc(1'b0),
    .dp_exc_res(32'h0), .dp_exc_nv(1'b0), .dp_exc_dz(1'b0),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_fp(out_fp3), .out_int(out_int3),
    .out_flags(out_flags3), .out_tag(out_tag3), .out_op_err(out_op_err3),
    .fflags(fflags3), .fflags_clr(fflags_clr), .busy(busy3));

  typedef struct {
    logic [23:0] op;
    logic [2:0]  frm;
    logic [3:0]  tag;
    logic [31:0] a, b, c, ival;
    logic [31:0] efp, eint;
    logic [4:0]  eflg;
    logic        eerr;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // issue one op, check exact latency, result fields, then retire it
  task automatic run_vec(input vec_t v, input logic clr, input string nm);
    @(negedge clk);
    in_valid = 1'b1; in_op = v.op; in_frm = v.frm; in_tag = v.tag;
    in_a = v.a; in_b = v.b; in_c = v.c; in_int = v.ival;
    #1 chk({nm, ".in_ready"}, 64'(in_ready), 64'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk({nm, ".early_valid"}, 64'(out_valid), 64'(0));
    chk({nm, ".busy"}, 64'(busy), 64'(1));
    @(posedge clk);
    @(negedge clk);
    chk({nm, ".out_valid"}, 64'(out_valid), 64'(1));
    chk({nm, ".out_fp"}, 64'(out_fp), 64'(v.efp));
    chk({nm, ".out_int"}, 64'(out_int), 64'(v.eint));
    chk({nm, ".out_flags"}, 64'(out_flags), 64'(v.eflg));
    chk({nm, ".out_op_err"}, 64'(out_op_err), 64'(v.eerr));
    chk({nm, ".out_tag"}, 64'(out_tag), 64'(v.tag));
    fflags_clr = clr;
    @(posedge clk);
    @(negedge clk);
    fflags_clr = 1'b0;
    chk({nm, ".retired"}, 64'(out_valid), 64'(0));
    chk({nm, ".idle_fp"}, 64'(out_fp), 64'(0));
  endtask

  task automatic clear_fflags();
    @(negedge clk); fflags_clr = 1'b1;
    @(posedge clk);
    @(negedge clk); fflags_clr = 1'b0;
    chk("fflags_clr", 64'(fflags), 64'(0));
  endtask

  vec_t tv[9];
  vec_t v;

  initial begin
    //         op            frm   tag   a             b             c             int           efp           eint          eflg      err
    tv[0] = '{24'h000001, 3'd0, 4'd5, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h0,        32'h40400000, 32'h0,        5'b00000, 1'b0}; // fadd
    tv[1] = '{24'h200000, 3'd0, 4'd1, 32'h0,        32'h0,        32'hDEADBEEF, 32'h00000200, 32'h0,        32'h00000200, 5'b00000, 1'b0}; // fclass
    tv[2] = '{24'h000003, 3'd0, 4'd2, 32'h1,        32'h1F,       32'h12345678, 32'h55,       32'h0,        32'h0,        5'b10000, 1'b1}; // multi-hot
    tv[3] = '{24'h000000, 3'd0, 4'd3, 32'h1,        32'h1F,       32'h12345678, 32'h55,       32'h0,        32'h0,        5'b10000, 1'b1}; // zero op
    tv[4] = '{24'h000080, 3'd7, 4'd4, 32'h0,        32'h1,        32'h0,        32'h0,        32'h7FC00000, 32'h7FC00000, 5'b11000, 1'b0}; // exc, int dst bit7
    tv[5] = '{24'h000001, 3'd7, 4'd6, 32'h0,        32'h0,        32'h3F800000, 32'h0,        32'h7FC00000, 32'h0,        5'b10000, 1'b0}; // exc, fp dst
    tv[6] = '{24'h000002, 3'd0, 4'd7, 32'h0,        32'h5,        32'h40800000, 32'h0,        32'h40800000, 32'h0,        5'b00101, 1'b0}; // fp op with flags
    tv[7] = '{24'h000200, 3'd1, 4'd8, 32'h0,        32'h2,        32'h11111111, 32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF, 5'b00010, 1'b0}; // bit9 int dst
    tv[8] = '{24'hC04000, 3'd0, 4'd9, 32'h0,        32'h0,        32'h1,        32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5, 5'b00000, 1'b0}; // bit14 + modifiers

    // reset state
    #2;
    chk("rst.out_valid", 64'(out_valid), 64'(0));
    chk("rst.busy", 64'(busy), 64'(0));
    chk("rst.fflags", 64'(fflags), 64'(0));
    chk("rst.out_fp", 64'(out_fp), 64'(0));
    @(negedge clk); rst_l = 1'b1;
    #1 chk("rst.in_ready", 64'(in_ready), 64'(1));

    for (int i = 0; i < 9; i++) run_vec(tv[i], 1'b0, $sformatf("vec%0d", i));

    // illegal op sets NV in fflags
    clear_fflags();
    run_vec(tv[2], 1'b0, "illegal");
    chk("illegal.fflags", 64'(fflags), 64'(5'b10000));

    // accrual then clear during a handshake
    clear_fflags();
    v = tv[0]; v.b = 32'h1; v.eflg = 5'b00001; run_vec(v, 1'b0, "acc1");
    v.b = 32'h4; v.eflg = 5'b00100;            run_vec(v, 1'b0, "acc2");
    chk("acc.fflags", 64'(fflags), 64'(5'b00101));
    v.b = 32'h10; v.eflg = 5'b10000;           run_vec(v, 1'b1, "acc3");
    chk("acc_clr.fflags", 64'(fflags), 64'(5'b10000));

    // backpressure on the LAT=3 instance: tags 0..3, 4-cycle stall at first output
    begin
      int nxt = 0, got = 0, stall_left = 4;
      bit started = 0, acc;
      for (int cyc = 0; cyc < 30; cyc++) begin
        @(negedge clk);
        if (out_valid3 && !started) started = 1;
        if (started && stall_left > 0) begin out_ready3 = 1'b0; stall_left--; end
        else out_ready3 = 1'b1;
        in_valid3 = (nxt < 4);
        in_tag3   = nxt[3:0];
        #1;
        if (!out_ready3) chk("bp.in_ready", 64'(in_ready3), 64'(0));
        if (out_valid3 && out_ready3) begin
          chk("bp.order", 64'(out_tag3), 64'(got));
          got++;
        end
        acc = in_valid3 && in_ready3;
        @(posedge clk);
        if (acc) nxt++;
      end
      @(negedge clk);
      in_valid3 = 1'b0;
      chk("bp.issued", 64'(nxt), 64'(4));
      chk("bp.count", 64'(got), 64'(4));
    end

    // async reset with an op at the output, no clock edge needed
    @(negedge clk);
    in_valid = 1'b1; in_op = 24'h1; in_frm = 3'd0; in_tag = 4'd5;
    in_a = 32'h3F800000; in_b = 32'h1; in_c = 32'h40400000; in_int = 32'h0;
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("arst.pre_valid", 64'(out_valid), 64'(1));
    chk("arst.pre_fflags", 64'(fflags), 64'(5'b10000));
    #2 rst_l = 1'b0;
    #1;
    chk("arst.out_valid", 64'(out_valid), 64'(0));
    chk("arst.busy", 64'(busy), 64'(0));
    chk("arst.fflags", 64'(fflags), 64'(0));
    chk("arst.out_fp", 64'(out_fp), 64'(0));
    @(negedge clk); rst_l = 1'b1;
    #1 chk("arst.in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    @(negedge clk);
    chk("arst.dropped", 64'(out_valid), 64'(0));
    chk("arst.fflags_after", 64'(fflags), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpu_pipe_top.md
Name: fpu_pipe_top

Overview:
- Parametrised, pipelined successor to the single-cycle FPU top.
- Accepts one FP instruction per cycle over a valid/ready handshake and registers operands into a datapath-facing stage.
- Carries the datapath result through a configurable-latency pipeline with global backpressure, masks the result by destination class, and keeps an accrued fflags CSR image.
- Sits between the issue logic and the existing combinational FPU units (input validation, FMADD, convert, compare, sign, move, classify), which attach through the dp_* ports.

Parameters:
- EXP, 8, exponent width.
- MAN, 23, stored mantissa width.
- FLEN, 1+EXP+MAN, operand/result width (derived; do not override).
- LAT, 2, cycles from input handshake to out_valid. Legal range 2..6.
- TAGW, 4, width of the tag carried alongside each op.
- INT_DST_MASK, 24'h204E80, op bits whose result goes to the integer register file (bits 7, 9, 10, 11, 14, 21).

Ports:
- clk  in  1  clock.
- rst_l  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when high with in_valid.
- in_op  in  24  sfpu opcode; bits[21:0] one-hot; bit22 = unsigned, bit23 = signed modifier.
- in_frm  in  3  rounding mode.
- in_tag  in  TAGW  opaque tag.
- in_a, in_b, in_c  in  FLEN  FP operands.
- in_int  in  32  integer operand.
- dp_op  out  24  registered op to datapath.
- dp_frm  out  3  registered rounding mode to datapath.
- dp_a, dp_b, dp_c  out  FLEN  registered operands to datapath.
- dp_int  out  32  registered integer operand to datapath.
- dp_fp_res  in  FLEN  datapath FP result, combinational from dp_*.
- dp_int_res  in  32  datapath integer result.
- dp_flags  in  5  datapath flags {NV,DZ,OF,UF,NX}.
- dp_exc  in  1  input-validation exception.
- dp_exc_res  in  FLEN  exception result (canonical NaN / inf).
- dp_exc_nv, dp_exc_dz  in  1  exception flags.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out_fp  out  FLEN  FP result.
- out_int  out  32  integer result.
- out_flags  out  5  per-op flags.
- out_tag  out  TAGW  echoed tag.
- out_op_err  out  1  illegal opcode.
- fflags  out  5  accrued flags.
- fflags_clr  in  1  synchronous clear of fflags.
- busy  out  1  any stage valid.

Behaviour:
- Reset (async, rst_l low): all stage valid bits, data registers, out_* and fflags go to 0 immediately. in_ready=1 while rst_l is high and the pipe is empty. In-flight ops are dropped, not completed.
- Stages: S1 holds the accepted operands and drives dp_*. The dp result is sampled into R1; R1..R(LAT-1) shift. out_* are driven from the last R stage.
- Accept at edge k gives out_valid from cycle k+LAT.
- Stall = out_valid & ~out_ready. On stall every stage holds and in_ready=0 combinationally.
- Bubbles are not compressed. Throughput is 1 op/cycle with out_ready high. Ordering is strict FIFO.
- Illegal op: in_op[21:0] zero or multi-hot. Result: out_fp=0, out_int=0, out_flags=5'b10000, out_op_err=1. dp inputs are ignored for that op.
- Exception (dp_exc=1, legal op):
  - out_fp = dp_exc_res.
  - out_int = dp_exc_res if bit 7 of the op is set, else 0.
  - out_flags = {dp_exc_nv, dp_exc_dz, 3'b000}.
- Normal op:
  - Op matches INT_DST_MASK: out_int = dp_int_res, out_fp = 0.
  - Otherwise: out_fp = dp_fp_res, out_int = 0.
  - out_flags = dp_flags.
- Flags are captured with the result in R1 and travel with it.
- fflags:
  - On handshake (out_valid & out_ready): fflags <= (fflags_clr ? 0 : fflags) | out_flags.
  - With fflags_clr and no handshake: fflags <= 0.
- busy = OR of all stage valid bits.
- out_* hold stable while stalled. Values are don't-care-free: 0 when out_valid=0.

Test Plan:
- Async reset mid-op: accept an op, drop rst_l between edges -> out_valid=0, busy=0, fflags=0 with no clock edge; in_ready=1 after release.
- Fadd, LAT=2: in_op=24'h000001, in_a=32'h3F800000, in_b=32'h40000000, dp_fp_res=32'h40400000, tag=5 -> out_valid exactly 2 cycles after accept, out_fp=32'h40400000, out_int=0, out_tag=5.
- Backpressure, LAT=3: issue tags 0..3 back-to-back, hold out_ready=0 after the first out_valid for 4 cycles -> in_ready=0 while stalled, no loss or duplication, tags emerge in order 0,1,2,3.
- Accrual and clear:
  - Two ops with dp_flags 5'b00001, then 5'b00100 -> fflags=5'b00101.
  - Third op flags 5'b10000 with fflags_clr in its handshake cycle -> fflags=5'b10000.
- Illegal op: in_op=24'h000003 -> out_op_err=1, out_flags=5'b10000, out_fp=0, out_int=0; fflags NV set.
- Fclass (in_op=24'h200000), dp_int_res=32'h00000200, dp_fp_res=32'hDEADBEEF -> out_int=32'h00000200, out_fp=0.
